// File: rtl/mips_mem_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  function automatic logic is_store(mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_legal(logic [3:0] op);
    case (mem_op_t'(op))
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // LWL/LWR are unaligned by design and never fault.
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_align.sv
// Combinational byte-lane steering: store lanes/enables and load extract/merge.
module mips_mem_align
  import mips_mem_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_offset,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] ld_result
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] shr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sh_r   = {ld_offset, 3'b000};
  assign sh_l   = {2'd3 - ld_offset, 3'b000};
  assign shr    = readdata >> sh_r;
  assign byte_v = shr[7:0];
  assign half_v = ld_offset[1] ? readdata[31:16] : readdata[15:0];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    byteenable = 4'b1111;
    writedata  = '0;
    case (mem_op_t'(st_op))
      OP_SB: begin
        byteenable = 4'b0001 << st_offset;
        writedata  = {4{wdata[7:0]}};
      end
      OP_SH: begin
        byteenable = st_offset[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
      end
      OP_SW:   writedata = wdata;
      default: ;
    endcase
  end

  always_comb begin
    ld_result = '0;
    case (mem_op_t'(ld_op))
      OP_LB:   ld_result = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ld_result = {24'h0, byte_v};
      OP_LH:   ld_result = {{16{half_v[15]}}, half_v};
      OP_LHU:  ld_result = {16'h0, half_v};
      OP_LW:   ld_result = readdata;
      OP_LWL:  ld_result = (readdata << sh_l) | (rt_old & ~(32'hFFFF_FFFF << sh_l));
      OP_LWR:  ld_result = shr | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
      default: ld_result = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_mem_unit.sv
// MEM-stage load/store unit: one request becomes one word-aligned Avalon transaction.
module mips_cpu_bus_mem_unit
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR_UNUSED = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_t      state;
  state_t      state_next;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_old_q;
  logic        req_bad;
  logic [3:0]  be_st;
  logic [31:0] wd_st;
  logic [31:0] ld_result;

  assign req_bad    = !is_legal(req_op) || is_misaligned(mem_op_t'(req_op), req_addr[1:0]);
  assign req_ready  = reset && (state == IDLE);
  assign resp_valid = (state == RESP);

  mips_mem_align u_align (
    .st_op      (req_op),
    .st_offset  (req_addr[1:0]),
    .wdata      (req_wdata),
    .byteenable (be_st),
    .writedata  (wd_st),
    .ld_op      (op_q),
    .ld_offset  (off_q),
    .readdata   (readdata),
    .rt_old     (rt_old_q),
    .ld_result  (ld_result)
  );

  // NOTE: reset is sampled on the clock edge, so an abandoned bus strobe drops at that same edge.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_bad ? RESP : BUS;
      BUS:     if (!waitrequest) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      rt_old_q   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q     <= mem_op_t'(req_op);
            off_q    <= req_addr[1:0];
            rt_old_q <= req_rt_old;
            if (req_bad) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 1'b0;
              address    <= {req_addr[31:2], 2'b00};
              read       <= !is_store(mem_op_t'(req_op));
              write      <= is_store(mem_op_t'(req_op));
              byteenable <= be_st;
              writedata  <= wd_st;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_rdata <= ld_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_mem_unit.sv
// Directed bench for the load/store unit: hand-computed expectations checked by immediate assertions.
module tb_mips_cpu_bus_mem_unit;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_mem_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rt_old  (req_rt_old),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the request across one posedge and returns at the next negedge.
  task automatic send(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rt);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rt_old = rt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_op      = 4'd0;
    req_addr    = '0;
    req_wdata   = '0;
    req_rt_old  = '0;
    waitrequest = 1'b0;
    readdata    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_address", address, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_wdata", writedata, 0);
    check("rst_be", byteenable, 0);
    reset = 1'b1;
    #1 check("ready_after_rst", req_ready, 1);

    // LW aligned, no stall
    readdata = 32'h0000_00C0;
    send(OP_LW, 32'hBFC0_0028, 0, 0);
    check("lw_read", read, 1);
    check("lw_write", write, 0);
    check("lw_addr", address, 32'hBFC0_0028);
    check("lw_be", byteenable, 4'b1111);
    check("lw_busy", req_ready, 0);
    check("lw_no_resp_yet", resp_valid, 0);
    @(negedge clk);
    check("lw_resp_valid", resp_valid, 1);
    check("lw_rdata", resp_rdata, 32'h0000_00C0);
    check("lw_err", resp_err, 0);
    check("lw_read_drop", read, 0);
    @(negedge clk);
    check("lw_resp_pulse", resp_valid, 0);
    check("lw_ready_again", req_ready, 1);

    // LB / LBU at offset 3
    readdata = 32'h80FF_1234;
    send(OP_LB, 32'h0000_1003, 0, 0);
    check("lb_addr", address, 32'h0000_1000);
    @(negedge clk);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    @(negedge clk);
    send(OP_LBU, 32'h0000_1003, 0, 0);
    @(negedge clk);
    check("lbu_rdata", resp_rdata, 32'h0000_0080);
    @(negedge clk);

    // LH upper half, sign extended
    send(OP_LH, 32'h0000_1002, 0, 0);
    @(negedge clk);
    check("lh_rdata", resp_rdata, 32'hFFFF_80FF);
    @(negedge clk);

    // SH with five stall cycles
    waitrequest = 1'b1;
    send(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 0);
    check("sh_write", write, 1);
    check("sh_read", read, 0);
    check("sh_be", byteenable, 4'b1100);
    check("sh_wdata", writedata, 32'hBEEF_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("sh_hold_write_%0d", i), write, 1);
      check($sformatf("sh_hold_addr_%0d", i), address, 32'h0000_2000);
      check($sformatf("sh_hold_be_%0d", i), byteenable, 4'b1100);
      check($sformatf("sh_no_resp_%0d", i), resp_valid, 0);
    end
    waitrequest = 1'b0;
    @(negedge clk);
    check("sh_resp_valid", resp_valid, 1);
    check("sh_rdata", resp_rdata, 0);
    check("sh_err", resp_err, 0);
    check("sh_write_drop", write, 0);
    @(negedge clk);
    check("sh_resp_pulse", resp_valid, 0);

    // SB lane steering
    send(OP_SB, 32'h0000_4001, 32'h0000_00A5, 0);
    check("sb_be", byteenable, 4'b0010);
    check("sb_wdata", writedata, 32'hA5A5_A5A5);
    @(negedge clk);
    @(negedge clk);

    // LWL / LWR merge
    readdata = 32'h4433_2211;
    send(OP_LWL, 32'h0000_0011, 0, 32'hAABB_CCDD);
    check("lwl_addr", address, 32'h0000_0010);
    @(negedge clk);
    check("lwl_rdata", resp_rdata, 32'h2211_CCDD);
    check("lwl_err", resp_err, 0);
    @(negedge clk);
    send(OP_LWR, 32'h0000_0011, 0, 32'hAABB_CCDD);
    @(negedge clk);
    check("lwr_rdata", resp_rdata, 32'hAA44_3322);
    @(negedge clk);

    // Misaligned LW: straight to error response
    send(OP_LW, 32'h0000_3002, 0, 0);
    check("mis_resp_valid", resp_valid, 1);
    check("mis_err", resp_err, 1);
    check("mis_read", read, 0);
    check("mis_write", write, 0);
    @(negedge clk);
    check("mis_resp_pulse", resp_valid, 0);
    check("mis_read_after", read, 0);

    // Undefined opcode
    send(mem_op_t'(4'd15), 32'h0000_5000, 0, 0);
    check("undef_err", resp_err, 1);
    check("undef_read", read, 0);
    check("undef_write", write, 0);
    @(negedge clk);

    // SW abandoned by reset on the third stall cycle
    waitrequest = 1'b1;
    send(OP_SW, 32'h0000_6000, 32'h1234_5678, 0);
    check("sw_write", write, 1);
    check("sw_be", byteenable, 4'b1111);
    check("sw_wdata", writedata, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_write", write, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_ready_in_rst", req_ready, 0);
    reset       = 1'b1;
    waitrequest = 1'b0;
    #1 check("abort_ready", req_ready, 1);
    @(negedge clk);
    check("abort_no_resp", resp_valid, 0);
    check("abort_write_idle", write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
